// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit add/subtract unit, CHUNK bits per clock, LSB chunk first.
// Ports: clk, rst (sync, active-high), start, sub, a, b -> busy, done, sum[N:0].
module adder_nbit_seq #(
  parameter int N     = 10,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   sum
);

  localparam int STEPS = N / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_sub;
  logic           r_c;
  logic [N:0]     r_sum;

  logic [CHUNK-1:0] w_bx;
  logic [CHUNK:0]   w_add;
  logic [N-1:0]     w_hi;
  logic [N-1:0]     w_lo_next;
  logic             w_last;

  // B is inverted for subtract; the initial carry of 1 completes two's complement.
  assign w_bx   = r_b[CHUNK-1:0] ^ {CHUNK{r_sub}};
  assign w_add  = {1'b0, r_a[CHUNK-1:0]}
                + {1'b0, w_bx}
                + {{CHUNK{1'b0}}, r_c};
  assign w_last = (r_cnt == CW'(STEPS - 1));

  // Result chunks enter at the top and shift down, so after STEPS
  // cycles the first (least-significant) chunk sits at bit 0.
  assign w_hi      = N'(w_add[CHUNK-1:0]) << (N - CHUNK);
  assign w_lo_next = (r_sum[N-1:0] >> CHUNK) | w_hi;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sub <= 1'b0;
      r_c   <= 1'b0;
      r_sum <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
            r_c   <= sub;
            r_cnt <= '0;
          end
        end
        CALC: begin
          r_a          <= r_a >> CHUNK;
          r_b          <= r_b >> CHUNK;
          r_c          <= w_add[CHUNK];
          r_cnt        <= r_cnt + CW'(1);
          r_sum[N-1:0] <= w_lo_next;
          // For subtract, borrow is the inverse of the final carry.
          if (w_last) r_sum[N] <= w_add[CHUNK] ^ r_sub;
        end
        default: ;
      endcase
    end
  end

  assign sum = r_sum;

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Bench for adder_nbit_seq: three instances (CHUNK=2,1,10) driven in parallel.
// Directed vectors plus start-during-CALC and reset-during-CALC sequences.
module tb_adder_nbit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [9:0]  a;
  logic [9:0]  b;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [10:0] sum_v [3];

  int ncmp;
  int nbad;
  int steps_t [3];

  typedef struct {
    logic        sub;
    logic [9:0]  a;
    logic [9:0]  b;
    logic [10:0] exp;
  } vec_t;

  vec_t vt [7];

  adder_nbit_seq #(.N(10), .CHUNK(2)) u_c2 (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0])
  );

  adder_nbit_seq #(.N(10), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1])
  );

  adder_nbit_seq #(.N(10), .CHUNK(10)) u_c10 (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s dut%0d: got %0d want %0d", nm, d, act, exp);
    end
  endtask

  // Starts one operation; start is sampled at edge k. Cycle c counts
  // negedges after edge k, so done is expected at c == STEPS.
  task automatic run_op(input logic s, input logic [9:0] va,
                        input logic [9:0] vb, input logic [10:0] ex,
                        input bit glitch);
    int bcnt [3];
    int dcnt [3];
    int dcyc [3];
    int dsum [3];
    for (int d = 0; d < 3; d++) begin
      bcnt[d] = 0;
      dcnt[d] = 0;
      dcyc[d] = -1;
      dsum[d] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    if (glitch) begin
      a = 10'd5;
      b = 10'd5;
      sub = 1'b0;
    end else begin
      start = 1'b0;
      a   = ~va;
      b   = ~vb;
      sub = ~s;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (busy_v[d]) bcnt[d]++;
        if (done_v[d]) begin
          dcnt[d]++;
          if (dcyc[d] < 0) dcyc[d] = c;
          dsum[d] = int'(sum_v[d]);
        end
      end
      if (c == 2) start = 1'b0;
    end
    for (int d = 0; d < 3; d++) begin
      chk("busy_cycles", d, bcnt[d], steps_t[d]);
      chk("done_count", d, dcnt[d], 1);
      chk("done_latency", d, dcyc[d], steps_t[d]);
      chk("sum_at_done", d, dsum[d], int'(ex));
      chk("sum_held", d, int'(sum_v[d]), int'(ex));
    end
  endtask

  task automatic run_reset_abort();
    int dlate [3];
    for (int d = 0; d < 3; d++) dlate[d] = 0;
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 10'd12;
    b     = 10'd28;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 3) begin
        for (int d = 0; d < 3; d++) begin
          chk("rst_busy", d, int'(busy_v[d]), 0);
          chk("rst_done", d, int'(done_v[d]), 0);
          chk("rst_sum", d, int'(sum_v[d]), 0);
        end
        rst = 1'b0;
      end
      if (c >= 3) begin
        for (int d = 0; d < 3; d++)
          if (done_v[d]) dlate[d]++;
      end
      // Asserted during the 3rd CALC cycle, sampled at edge k+3.
      if (c == 2) rst = 1'b1;
    end
    for (int d = 0; d < 3; d++)
      chk("no_done_after_rst", d, dlate[d], 0);
  endtask

  initial begin
    ncmp = 0;
    nbad = 0;
    steps_t[0] = 5;
    steps_t[1] = 10;
    steps_t[2] = 1;
    vt[0] = '{1'b0, 10'd12,   10'd28,   11'd40};
    vt[1] = '{1'b0, 10'd1023, 10'd1023, 11'd2046};
    vt[2] = '{1'b0, 10'd120,  10'd68,   11'd188};
    vt[3] = '{1'b1, 10'd120,  10'd68,   11'd52};
    vt[4] = '{1'b1, 10'd0,    10'd1,    11'd2047};
    vt[5] = '{1'b1, 10'd68,   10'd120,  11'd1996};
    vt[6] = '{1'b1, 10'd5,    10'd5,    11'd0};

    rst   = 1'b1;
    start = 1'b1;
    sub   = 1'b0;
    a     = 10'd3;
    b     = 10'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", d, int'(busy_v[d]), 0);
      chk("reset_done", d, int'(done_v[d]), 0);
      chk("reset_sum", d, int'(sum_v[d]), 0);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk("idle_sum", d, int'(sum_v[d]), 0);

    for (int i = 0; i < 7; i++)
      run_op(vt[i].sub, vt[i].a, vt[i].b, vt[i].exp, 1'b0);

    run_op(1'b0, 10'd12, 10'd28, 11'd40, 1'b1);

    run_reset_abort();

    run_op(1'b0, 10'd120, 10'd68, 11'd188, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/adder_nbit_seq.md
ADDER_NBIT_SEQ -- requirements
Module: adder_nbit_seq

Interface
REQ-001 The block SHALL have parameter N, default 10, meaning operand width in bits (N >= 1).
REQ-002 The block SHALL have parameter CHUNK, default 2, meaning bits added per clock cycle (1 <= CHUNK <= N, N divisible by CHUNK).
REQ-003 The block SHALL define STEPS = N/CHUNK as its compute-cycle count.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-007 The block SHALL have port sub  input  1  mode: 0 = add, 1 = subtract; captured with start.
REQ-008 The block SHALL have port a  input  N  unsigned operand A; captured with start.
REQ-009 The block SHALL have port b  input  N  unsigned operand B; captured with start.
REQ-010 The block SHALL have port busy  output  1  high while in CALC.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse when sum becomes valid.
REQ-012 The block SHALL have port sum  output  N+1  registered result.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE with start=1 at an edge SHALL capture a, b and sub, clear the step counter and internal carry, and enter CALC.
- Carry initialises to 0 for add and 1 for subtract.
REQ-015 IDLE with start=0 SHALL remain in IDLE with all outputs held.
REQ-016 Each CALC cycle SHALL add CHUNK bits, least-significant chunk first, using the carry from the previous step.
- Operand B is inverted when sub=1.
- The chunk result is stored into the result register; the chunk carry-out is stored as the new internal carry.
REQ-017 CALC SHALL last exactly STEPS cycles, then transition to DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then transition to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle after edge k+STEPS.
- Minimum start-to-start spacing is STEPS+2 cycles.
REQ-020 Add mode SHALL produce sum = a + b exactly, with bit N the final carry-out.
REQ-021 Subtract mode SHALL produce sum = (a - b) mod 2^(N+1).
- Bit N = 1 exactly when a < b.
REQ-022 start SHALL be ignored in CALC and DONE, with no effect on captured operands or result.
REQ-023 Changes on a, b or sub after capture SHALL NOT affect the operation in progress.
REQ-024 sum SHALL hold its last completed value from DONE until the next operation's first CALC edge.
- During CALC, sum is don't-care to the consumer; it is only qualified by done.
REQ-025 When CHUNK = N, the block SHALL complete in one CALC cycle with results identical to any other legal CHUNK.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, and clear the internal carry and step counter, regardless of current state.
REQ-027 rst=1 SHALL have priority over start in the same cycle.
REQ-028 Reset during CALC SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave normally.

Verification (N=10, CHUNK=2, STEPS=5)
REQ-029 Bench SHALL check: add a=12, b=28, start at edge k -> busy high for 5 cycles, done pulse after edge k+5, sum=40.
REQ-030 Bench SHALL check: add a=1023, b=1023 -> sum=2046 (bit 10 set); then add a=120, b=68 -> sum=188.
REQ-031 Bench SHALL check: subtract a=120, b=68 -> sum=52; subtract a=0, b=1 -> sum=2047.
REQ-032 Bench SHALL check: start re-asserted with a=5, b=5 during CALC of 12+28 -> ignored, sum=40, exactly one done pulse.
REQ-033 Bench SHALL check: rst asserted on the 3rd CALC cycle -> next cycle busy=0, done=0, sum=0, and no done pulse follows.
REQ-034 Bench SHALL repeat the REQ-029 to REQ-031 vectors with CHUNK=1 (STEPS=10) and CHUNK=10 (STEPS=1) -> identical sums, latency scaled accordingly.
